// File: rtl/ex_div_pkg.sv
// ex_div_pkg
//   Shared types and constants for the execute-stage divider.
//   div_state_t  : divider FSM state encoding
//   DIV_ITER     : quotient bits produced per divide (one per BUSY cycle)
//   DIV_RESULT_W : width of the {remainder, quotient} HI/LO pair
package ex_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } div_state_t;

  localparam int DIV_ITER     = 32;
  localparam int DIV_RESULT_W = 64;

endpackage

// File: rtl/ex_div_step.sv
// div_step
//   One restoring-division step, purely combinational.
//   rem_in  : shifted partial remainder {rem, next dividend bit}, WIDTH+1 bits
//   divisor : divisor magnitude
//   rem_out : partial remainder after the trial subtraction
//   q_bit   : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // rem_in is always below 2*divisor, so a non-negative difference fits in
  // WIDTH bits and a restored value also fits in WIDTH bits.
  assign diff    = rem_in - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];

endmodule

// File: rtl/ex_div.sv
// ex_div
//   Multi-cycle 32-bit signed/unsigned divider for DIV/DIVU in execute.
//   Produces {remainder, quotient} as the HI/LO write pair.
//
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   start      : divide request, held by execute until ready
//   annul      : abort (flush/exception), wins over start
//   signed_div : 1 = DIV, 0 = DIVU
//   dividend   : operand A, sampled when leaving IDLE
//   divisor    : operand B, sampled when leaving IDLE
//   result     : {remainder, quotient}, valid while ready
//   ready      : registered, high in every DONE cycle
//   stall_req  : start & ~ready & ~annul
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; operands and sign flags latched on exit
//   DIVZERO | divisor was zero; goes to DONE with a zero result
//   BUSY    | one restoring step per cycle, 32 cycles, MSB first
//   DONE    | result held and ready high until start drops or annul
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    annul,
  input  logic                    signed_div,
  input  logic [WIDTH-1:0]        dividend,
  input  logic [WIDTH-1:0]        divisor,
  output logic [DIV_RESULT_W-1:0] result,
  output logic                    ready,
  output logic                    stall_req
);

  localparam logic [5:0] LAST_ITER = 6'(DIV_ITER - 1);

  div_state_t       state;
  logic [5:0]       iter_cnt;
  logic [WIDTH-1:0] quo_q;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             abort;

  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign a_neg = signed_div & dividend[WIDTH-1];
  assign b_neg = signed_div & divisor[WIDTH-1];
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

  // Dropping start mid-operation is treated exactly like annul.
  assign abort = annul | ~start;

  assign stall_req = start & ~ready & ~annul;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  ({rem_q, quo_q[WIDTH-1]}),
    .divisor (dvsr_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign quo_nxt = {quo_q[WIDTH-2:0], q_bit};
  assign quo_fix = q_neg ? (~quo_nxt + 1'b1) : quo_nxt;
  assign rem_fix = r_neg ? (~rem_nxt + 1'b1) : rem_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      iter_cnt <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start && !annul) begin
            quo_q    <= a_mag;
            dvsr_q   <= b_mag;
            rem_q    <= '0;
            iter_cnt <= '0;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            state    <= (divisor == '0) ? DIVZERO : BUSY;
          end
        end

        DIVZERO: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            state  <= DONE;
            ready  <= 1'b1;
            result <= '0;
          end
        end

        BUSY: begin
          if (abort) begin
            state    <= IDLE;
            iter_cnt <= '0;
          end else begin
            quo_q    <= quo_nxt;
            rem_q    <= rem_nxt;
            iter_cnt <= iter_cnt + 6'd1;
            if (iter_cnt == LAST_ITER) begin
              state    <= DONE;
              ready    <= 1'b1;
              iter_cnt <= '0;
              result   <= {rem_fix, quo_fix};
            end
          end
        end

        DONE: begin
          if (abort) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int n_cmp = 0;
  int n_err = 0;

  ex_div #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero; remainder
  // takes the dividend's sign. Divide by zero yields all zeros.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issues one request and waits for ready. lat counts cycles from the
  // request cycle (0) to the first cycle with ready high. stall_ok records
  // whether stall_req was high in every waiting cycle and low once ready.
  // Operands are scrambled after the request edge; that must not matter.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res, output bit stall_ok);
    @(posedge clk); #1;
    start      = 1'b1;
    annul      = 1'b0;
    signed_div = sgn;
    dividend   = a;
    divisor    = b;
    lat        = 0;
    stall_ok   = 1'b1;
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (stall_req !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall_req !== 1'b1) stall_ok = 1'b0;
      if (lat >= 200) break;
      @(posedge clk); #1;
      lat++;
      dividend   = $urandom;
      divisor    = $urandom;
      signed_div = 1'($urandom_range(0, 1));
    end
    res = result;
  endtask

  task automatic drop_start();
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
    n_cmp++;
    if (result !== 64'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++;
    if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_req); end
    start = 1'b1; #1;
    n_cmp++;
    if (stall_req !== 1'b1) begin n_err++; $display("FAIL reset_stall_start got %b want 1", stall_req); end
    start = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res; bit sok;
    run_div(1'b0, 32'd100, 32'd7, lat, res, sok);
    n_cmp++;
    if (lat !== 33) begin n_err++; $display("FAIL divu_latency got %0d want 33", lat); end
    n_cmp++;
    if (res !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_100_7 got %h want %h", res, {32'd2, 32'd14}); end
    n_cmp++;
    if (sok !== 1'b1) begin n_err++; $display("FAIL divu_stall got %b want 1", sok); end
    drop_start();
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res; bit sok;
    run_div(1'b1, -32'sd7, 32'sd2, lat, res, sok);
    n_cmp++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin n_err++; $display("FAIL div_m7_2 got %h want ffffffff_fffffffd", res); end
    drop_start();
    run_div(1'b1, 32'sd7, -32'sd2, lat, res, sok);
    n_cmp++;
    if (res !== {32'h1, 32'hFFFFFFFD}) begin n_err++; $display("FAIL div_7_m2 got %h want 00000001_fffffffd", res); end
    n_cmp++;
    if (lat !== 33) begin n_err++; $display("FAIL div_latency got %0d want 33", lat); end
    drop_start();
  endtask

  task automatic test_zero_overflow();
    int lat; logic [63:0] res; bit sok;
    run_div(1'b0, 32'd55, 32'd0, lat, res, sok);
    n_cmp++;
    if (lat !== 2) begin n_err++; $display("FAIL divzero_latency got %0d want 2", lat); end
    n_cmp++;
    if (res !== 64'h0) begin n_err++; $display("FAIL divzero_result got %h want 0", res); end
    n_cmp++;
    if (sok !== 1'b1) begin n_err++; $display("FAIL divzero_stall got %b want 1", sok); end
    drop_start();
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res, sok);
    n_cmp++;
    if (res !== {32'h0, 32'h80000000}) begin n_err++; $display("FAIL div_overflow got %h want 00000000_80000000", res); end
    drop_start();
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, lat, res, sok);
    n_cmp++;
    if (res !== {32'h0, 32'hFFFFFFFF}) begin n_err++; $display("FAIL divu_max_1 got %h want 00000000_ffffffff", res); end
    drop_start();
  endtask

  task automatic test_random();
    int lat; logic [63:0] res, exp_res; bit sok; bit sgn;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       begin a = 32'($urandom_range(0, 100)); b = $urandom; end
        default: b = $urandom;
      endcase
      exp_res = model(sgn, a, b);
      run_div(sgn, a, b, lat, res, sok);
      n_cmp++;
      if (res !== exp_res) begin
        n_err++;
        $display("FAIL rand_result sgn=%0d a=%h b=%h got %h want %h", sgn, a, b, res, exp_res);
      end
      n_cmp++;
      if (lat !== ((b == 32'd0) ? 2 : 33)) begin
        n_err++;
        $display("FAIL rand_latency a=%h b=%h got %0d want %0d", a, b, lat, (b == 32'd0) ? 2 : 33);
      end
      n_cmp++;
      if (sok !== 1'b1) begin n_err++; $display("FAIL rand_stall got %b want 1", sok); end
      drop_start();
    end
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; bit sok; bit seen;
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    #1;
    n_cmp++;
    if (stall_req !== 1'b0) begin n_err++; $display("FAIL annul_stall got %b want 0", stall_req); end
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL annul_ready got %b want 0", seen); end
    run_div(1'b0, 32'd9, 32'd3, lat, res, sok);
    n_cmp++;
    if (res !== {32'd0, 32'd3}) begin n_err++; $display("FAIL after_annul got %h want 00000000_00000003", res); end
    n_cmp++;
    if (lat !== 33) begin n_err++; $display("FAIL after_annul_latency got %0d want 33", lat); end
    drop_start();
  endtask

  task automatic test_hold();
    int lat; logic [63:0] res; bit sok; bit stable;
    run_div(1'b1, -32'sd100, 32'sd7, lat, res, sok);
    n_cmp++;
    if (res !== model(1'b1, -32'sd100, 32'sd7)) begin n_err++; $display("FAIL hold_result got %h want %h", res, model(1'b1, -32'sd100, 32'sd7)); end
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ready !== 1'b1 || result !== res) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin n_err++; $display("FAIL hold_stable got %b want 1", stable); end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL hold_drop_same_cycle got %b want 1", ready); end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL hold_drop_ready got %b want 0", ready); end
    // Back-to-back: a fresh request straight out of IDLE.
    run_div(1'b0, 32'd4000000000, 32'd3, lat, res, sok);
    n_cmp++;
    if (res !== model(1'b0, 32'd4000000000, 32'd3)) begin n_err++; $display("FAIL back_to_back got %h want %h", res, model(1'b0, 32'd4000000000, 32'd3)); end
    drop_start();
  endtask

  task automatic test_async_reset();
    int lat; logic [63:0] res; bit sok;
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; dividend = 32'd12345; divisor = 32'd17;
    repeat (15) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL async_rst_ready got %b want 0", ready); end
    n_cmp++;
    if (result !== 64'h0) begin n_err++; $display("FAIL async_rst_result got %h want 0", result); end
    start = 1'b0;
    @(negedge clk); reset = 1'b0;
    run_div(1'b0, 32'd12345, 32'd17, lat, res, sok);
    n_cmp++;
    if (res !== {32'd3, 32'd726}) begin n_err++; $display("FAIL after_reset got %h want 00000003_000002d6", res); end
    n_cmp++;
    if (lat !== 33) begin n_err++; $display("FAIL after_reset_latency got %0d want 33", lat); end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero_overflow();
    test_random();
    test_annul();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
